// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the PC register input, issues imem reads and fills IF/ID.
// Handles variable-latency memory, ID stalls, redirect flushes (with stale-response drain) and HLT.
module fetch_stage #(
    parameter int unsigned ADDR_W      = 16,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_val,
    output logic [ADDR_W-1:0] pc_next,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [ADDR_W-1:0] imem_rdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              ifid_valid,
    output logic [ADDR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc_plus2,
    output logic              halted
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DRAIN = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc_plus2;
    logic              advance;
    logic              is_halt;

    assign pc_plus2  = pc_val + ADDR_W'(2);
    assign advance   = (state == S_FETCH) && imem_ack && !stall;
    assign is_halt   = (imem_rdata[ADDR_W-1 -: 4] == HALT_OPCODE);
    assign imem_addr = pc_val;

    // PC register is always enabled, so holding means feeding pc_val back
    always_comb begin
        pc_next  = pc_val;
        imem_req = 1'b0;
        if (redirect) begin
            pc_next = {redirect_pc[ADDR_W-1:1], 1'b0};
        end else if (state == S_FETCH) begin
            imem_req = 1'b1;
            if (advance) begin
                pc_next = pc_plus2;
            end
        end
    end

    // State and IF/ID register; redirect beats stall beats ack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_FETCH;
            ifid_valid    <= 1'b0;
            ifid_instr    <= '0;
            ifid_pc_plus2 <= '0;
            halted        <= 1'b0;
        end else if (redirect) begin
            ifid_valid <= 1'b0;
            halted     <= 1'b0;
            // an unanswered request will still return data that must be dropped
            state      <= ((state == S_FETCH) && !imem_ack) ? S_DRAIN : S_FETCH;
        end else begin
            case (state)
                S_FETCH: begin
                    if (advance) begin
                        ifid_valid    <= 1'b1;
                        ifid_instr    <= imem_rdata;
                        ifid_pc_plus2 <= pc_plus2;
                        if (is_halt) begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end
                    end else if (!stall) begin
                        ifid_valid <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (!stall) begin
                        ifid_valid <= 1'b0;
                    end
                    if (imem_ack) begin
                        state <= S_FETCH;
                    end
                end
                S_HALT: begin
                    if (!stall) begin
                        ifid_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule
